// File: rtl/user_reg_pkg.sv
// Shared definitions for the user register block.
// Contents:
//   USER_REG_WORD_ADDR_WIDTH / USER_REG_DATA_WIDTH : default register geometry
//   USER_REG_MAX_REQ / REQ_IDX_W / req_idx_t       : requester index type, sized for the largest legal NUM_REQ
//   next_ptr()                                     : round-robin pointer successor with wrap to 0
package user_reg_pkg;

  localparam int unsigned USER_REG_WORD_ADDR_WIDTH = 4;
  localparam int unsigned USER_REG_DATA_WIDTH      = 32;
  localparam int unsigned USER_REG_MAX_REQ         = 4;
  localparam int unsigned REQ_IDX_W                = $clog2(USER_REG_MAX_REQ);

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  // Index following idx, wrapping num_req-1 back to 0.
  function automatic req_idx_t next_ptr(input req_idx_t idx, input int unsigned num_req);
    if ((32'(idx) + 32'd1) >= num_req) begin
      return '0;
    end
    return REQ_IDX_W'(32'(idx) + 32'd1);
  endfunction

endpackage

// File: rtl/user_reg_rr_pick.sv
// Combinational rotating-priority picker.
// Starting at ptr_i, the first set bit of valid_i (searching upward with wrap)
// wins.
// Ports:
//   valid_i [NUM_REQ] : request vector
//   ptr_i             : search start index (must be < NUM_REQ)
//   grant_o [NUM_REQ] : one-hot grant (all-zero when nothing is valid)
//   idx_o             : index of the granted requester (0 when none)
//   any_o             : at least one request present
module user_reg_rr_pick
  import user_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  req_idx_t           ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output req_idx_t           idx_o,
  output logic               any_o
);

  req_idx_t cand;
  logic     found;

  // Walk NUM_REQ slots from the pointer; the first valid slot wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = REQ_IDX_W'((32'(ptr_i) + k) % NUM_REQ);
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/user_reg_wr_arb.sv
// Write arbiter for the user register bank: up to NUM_REQ requesters share
// one register-bank write port. One grant per cycle, latency of one cycle
// from acceptance to the wr_* pulse.
// Ports:
//   ACLK, ARESETn                       : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o [NUM_REQ] : per-requester handshake (ready is combinational)
//   req_addr_i / req_data_i / req_strb_i: per-requester payload
//   wr_stall_i                          : bank busy, blocks every grant
//   wr_valid_o/_addr_o/_data_o/_strb_o  : registered bank write port
//   wr_src_o                            : requester index that produced the current write
// Build option: define USER_REG_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); otherwise round-robin.
module user_reg_wr_arb
  import user_reg_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned WORD_ADDR_WIDTH = USER_REG_WORD_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = USER_REG_DATA_WIDTH,
  parameter int unsigned STRB_WIDTH      = DATA_WIDTH / 8
) (
  input  logic                                    ACLK,
  input  logic                                    ARESETn,
  input  logic [NUM_REQ-1:0]                      req_valid_i,
  output logic [NUM_REQ-1:0]                      req_ready_o,
  input  logic [NUM_REQ-1:0][WORD_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data_i,
  input  logic [NUM_REQ-1:0][STRB_WIDTH-1:0]      req_strb_i,
  input  logic                                    wr_stall_i,
  output logic                                    wr_valid_o,
  output logic [WORD_ADDR_WIDTH-1:0]              wr_addr_o,
  output logic [DATA_WIDTH-1:0]                   wr_data_o,
  output logic [STRB_WIDTH-1:0]                   wr_strb_o,
  output logic [$clog2(NUM_REQ)-1:0]              wr_src_o
);

  localparam int unsigned SRC_W = $clog2(NUM_REQ);

  req_idx_t                   ptr_q, ptr_d;
  req_idx_t                   pick_idx;
  logic [NUM_REQ-1:0]         pick_grant;
  logic                       pick_any;

  logic                       wr_valid_q, wr_valid_d;
  logic [WORD_ADDR_WIDTH-1:0] wr_addr_q,  wr_addr_d;
  logic [DATA_WIDTH-1:0]      wr_data_q,  wr_data_d;
  logic [STRB_WIDTH-1:0]      wr_strb_q,  wr_strb_d;
  logic [SRC_W-1:0]           wr_src_q,   wr_src_d;

  // Rotating pick from the current pointer; fixed priority keeps it at 0.
  user_reg_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Grant, payload capture and pointer update; stall freezes everything
  // except the pulse already registered from the previous cycle.
  always_comb begin
    req_ready_o = '0;
    ptr_d       = ptr_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_strb_d   = wr_strb_q;
    wr_src_d    = wr_src_q;
    if (pick_any && !wr_stall_i) begin
      req_ready_o = pick_grant;
      wr_valid_d  = 1'b1;
      wr_addr_d   = req_addr_i[pick_idx];
      wr_data_d   = req_data_i[pick_idx];
      wr_strb_d   = req_strb_i[pick_idx];
      wr_src_d    = SRC_W'(pick_idx);
`ifdef USER_REG_ARB_FIXED_PRIO_EN
      ptr_d       = '0;
`else
      ptr_d       = next_ptr(pick_idx, NUM_REQ);
`endif
    end
  end

  // Registered write port and pointer.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ptr_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_strb_q  <= '0;
      wr_src_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_strb_q  <= wr_strb_d;
      wr_src_q   <= wr_src_d;
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign wr_strb_o  = wr_strb_q;
  assign wr_src_o   = wr_src_q;

endmodule

// File: tb/tb_user_reg_wr_arb.sv
// Self-checking bench for user_reg_wr_arb (NUM_REQ=2). A reference model
// predicts grants each cycle and queues the expected bank write; the monitor
// pops and compares whenever the write port is due. Define
// USER_REG_ARB_FIXED_PRIO_EN for both DUT and bench to check fixed priority.
module tb_user_reg_wr_arb;

  localparam int NR    = 2;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int SRC_W = $clog2(NR);

  logic                   ACLK;
  logic                   ARESETn;
  logic [NR-1:0]          req_valid_i;
  logic [NR-1:0]          req_ready_o;
  logic [NR-1:0][AW-1:0]  req_addr_i;
  logic [NR-1:0][DW-1:0]  req_data_i;
  logic [NR-1:0][SW-1:0]  req_strb_i;
  logic                   wr_stall_i;
  logic                   wr_valid_o;
  logic [AW-1:0]          wr_addr_o;
  logic [DW-1:0]          wr_data_o;
  logic [SW-1:0]          wr_strb_o;
  logic [SRC_W-1:0]       wr_src_o;

  user_reg_wr_arb #(
    .NUM_REQ (NR)
  ) dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_strb_i  (req_strb_i),
    .wr_stall_i  (wr_stall_i),
    .wr_valid_o  (wr_valid_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .wr_strb_o   (wr_strb_o),
    .wr_src_o    (wr_src_o)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    int            src;
  } item_t;

  item_t         q[$];
  item_t         last;
  int            p_m;
  int            cyc;
  int            n_vec;
  int            n_err;
  logic [NR-1:0] acc_q;

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference arbitration: first valid requester found walking up from p.
  function automatic int model_pick(input logic [NR-1:0] v, input logic st, input int p);
    if (st || v == '0) return -1;
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  // Monitor first (write due from last cycle), then model this cycle's grant.
  always @(negedge ACLK) begin
    item_t it;
    int g;
    logic [NR-1:0] exp_rdy;
    if (!ARESETn) begin
      q.delete();
      p_m   = 0;
      last  = '{cyc: 0, addr: '0, data: '0, strb: '0, src: 0};
      acc_q = '0;
    end else begin
      if (q.size() > 0 && q[0].cyc == cyc - 1) begin
        it = q.pop_front();
        check("wr_valid_o", 64'(wr_valid_o), 64'd1);
        check("wr_addr_o",  64'(wr_addr_o),  64'(it.addr));
        check("wr_data_o",  64'(wr_data_o),  64'(it.data));
        check("wr_strb_o",  64'(wr_strb_o),  64'(it.strb));
        check("wr_src_o",   64'(wr_src_o),   64'(it.src));
        last = it;
      end else begin
        check("wr_valid_o idle", 64'(wr_valid_o), 64'd0);
        check("wr_addr_o hold",  64'(wr_addr_o),  64'(last.addr));
        check("wr_data_o hold",  64'(wr_data_o),  64'(last.data));
        check("wr_src_o hold",   64'(wr_src_o),   64'(last.src));
      end
`ifdef USER_REG_ARB_FIXED_PRIO_EN
      g = model_pick(req_valid_i, wr_stall_i, 0);
`else
      g = model_pick(req_valid_i, wr_stall_i, p_m);
`endif
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready_o", 64'(req_ready_o), 64'(exp_rdy));
      if (g >= 0) begin
        q.push_back('{cyc: cyc, addr: req_addr_i[g], data: req_data_i[g],
                      strb: req_strb_i[g], src: g});
        p_m = (g + 1) % NR;
      end
      acc_q = req_valid_i & req_ready_o;
    end
  end

  // One cycle of stimulus; an unaccepted request keeps its valid and payload.
  task automatic drive(input logic [NR-1:0] v, input logic st);
    @(posedge ACLK);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (!(req_valid_i[i] && !acc_q[i])) begin
        req_valid_i[i] = v[i];
        req_addr_i[i]  = AW'($urandom);
        req_data_i[i]  = $urandom;
        req_strb_i[i]  = SW'($urandom);
      end
    end
    wr_stall_i = st;
  endtask

  task automatic idle(input int n);
    repeat (n) drive('0, 1'b0);
  endtask

  // Reset pulse a few ns after an edge; outputs must clear immediately.
  task automatic do_reset();
    @(posedge ACLK);
    #3 ARESETn = 1'b0;
    #1;
    check("rst wr_valid_o", 64'(wr_valid_o), 64'd0);
    check("rst wr_addr_o",  64'(wr_addr_o),  64'd0);
    check("rst wr_data_o",  64'(wr_data_o),  64'd0);
    check("rst wr_strb_o",  64'(wr_strb_o),  64'd0);
    check("rst wr_src_o",   64'(wr_src_o),   64'd0);
    @(posedge ACLK);
    #2 ARESETn = 1'b1;
  endtask

  initial begin
    cyc         = 0;
    n_vec       = 0;
    n_err       = 0;
    p_m         = 0;
    acc_q       = '0;
    ARESETn     = 1'b0;
    req_valid_i = '0;
    req_addr_i  = '0;
    req_data_i  = '0;
    req_strb_i  = '0;
    wr_stall_i  = 1'b0;
    #12;
    check("init wr_valid_o", 64'(wr_valid_o), 64'd0);
    check("init wr_addr_o",  64'(wr_addr_o),  64'd0);
    check("init wr_data_o",  64'(wr_data_o),  64'd0);
    check("init wr_strb_o",  64'(wr_strb_o),  64'd0);
    check("init wr_src_o",   64'(wr_src_o),   64'd0);
    check("init req_ready_o", 64'(req_ready_o), 64'd0);
    @(posedge ACLK);
    #2 ARESETn = 1'b1;

    // Single write from requester 0 with a known payload.
    drive(2'b01, 1'b0);
    req_addr_i[0] = 4'd3;
    req_data_i[0] = 32'hDEADBEEF;
    req_strb_i[0] = 4'hF;
    idle(3);

    // Both requesters continuously valid from a fresh pointer.
    do_reset();
    repeat (4) drive(2'b11, 1'b0);
    idle(3);

    // Stall with both valid, then release.
    do_reset();
    repeat (3) drive(2'b11, 1'b1);
    repeat (2) drive(2'b11, 1'b0);
    idle(3);

    // Requester-1 acceptance followed by a stall cycle.
    drive(2'b10, 1'b0);
    drive(2'b00, 1'b1);
    idle(3);

    // Reset in the middle of a busy stream.
    repeat (3) drive(2'b11, 1'b0);
    do_reset();
    repeat (3) drive(2'b11, 1'b0);
    idle(3);

    // Random traffic with occasional stalls.
    repeat (400) drive(NR'($urandom), ($urandom_range(0, 3) == 0));
    idle(4);
    check("queue drained", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/user_reg_wr_arb.md
USER_REG_WR_ARB -- requirements
Module: user_reg_wr_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of write requesters (legal range 2..4).
REQ-002 SHALL have parameter WORD_ADDR_WIDTH, default 4, register word-address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-004 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8, byte-strobe width.
REQ-005 SHALL have ports: ACLK input 1 clock; ARESETn input 1 asynchronous active-low reset.
REQ-006 SHALL have ports: req_valid_i input NUM_REQ, per-requester write request; req_ready_o output NUM_REQ, per-requester accept.
REQ-007 SHALL have ports: req_addr_i input NUM_REQ x WORD_ADDR_WIDTH, req_data_i input NUM_REQ x DATA_WIDTH, req_strb_i input NUM_REQ x STRB_WIDTH, per-requester payload.
REQ-008 SHALL have port wr_stall_i input 1, register bank busy; blocks all grants.
REQ-009 SHALL have ports: wr_valid_o output 1, wr_addr_o output WORD_ADDR_WIDTH, wr_data_o output DATA_WIDTH, wr_strb_o output STRB_WIDTH, single register-bank write port.
REQ-010 SHALL have port wr_src_o output $clog2(NUM_REQ), index of requester that produced the current write.

Function
REQ-011 SHALL grant at most one requester per cycle; req_ready_o[i]=1 only for the granted i, combinationally from req_valid_i, wr_stall_i and the priority pointer.
REQ-012 SHALL treat a transfer as accepted on a cycle with req_valid_i[i] && req_ready_o[i].
REQ-013 SHALL drive req_ready_o all-zero whenever wr_stall_i=1 or no req_valid_i bit is set.
REQ-014 SHALL register the accepted payload and present it on wr_* the cycle after acceptance, wr_valid_o high for exactly one cycle per accepted transfer (latency 1).
REQ-015 SHALL hold wr_addr_o/wr_data_o/wr_strb_o/wr_src_o at last accepted values when wr_valid_o=0.
REQ-016 SHALL sustain one write per cycle with back-to-back acceptances.
REQ-017 SHALL use round-robin: search starts at pointer p; after an acceptance by i, p becomes (i+1) mod NUM_REQ; p unchanged on cycles without acceptance.
REQ-018 SHALL wrap p from NUM_REQ-1 to 0.
REQ-019 SHALL not advance p or accept while wr_stall_i=1; stall asserted in the cycle after acceptance does not cancel the pending wr_valid_o pulse.
REQ-020 SHALL perform no address-collision merging; same-address writes emerge in grant order, later overwrites earlier.
REQ-021 SHALL ignore payload of non-granted requesters; requesters hold payload stable while valid and not ready.

Reset
REQ-022 SHALL on ARESETn low, asynchronously: wr_valid_o=0, wr_addr_o=0, wr_data_o=0, wr_strb_o=0, wr_src_o=0, p=0.
REQ-023 SHALL drop any transfer accepted in the cycle reset asserts; first grant after deassert follows p=0.

Configuration
REQ-024 SHALL, with USER_REG_ARB_FIXED_PRIO_EN defined, use fixed priority: lowest valid index always wins, p held at 0.
REQ-025 SHALL, without USER_REG_ARB_FIXED_PRIO_EN, use round-robin per REQ-017/018.

Structure
REQ-026 SHALL take default WORD_ADDR_WIDTH, DATA_WIDTH and the requester-index typedef from shared package user_reg_pkg.
REQ-027 SHALL implement the pointer-based pick as sub-module user_reg_rr_pick (inputs valid vector and p; output one-hot grant and index), combinational.

Verification
REQ-028 SHALL cover: reset, req_valid_i=2'b01, addr0=3, data0=0xDEADBEEF, strb0=0xF -> ready=01 same cycle; next cycle wr_valid_o=1, wr_addr_o=3, wr_data_o=0xDEADBEEF, wr_src_o=0.
REQ-029 SHALL cover: both valid continuously for 4 cycles, NUM_REQ=2 -> grants 0,1,0,1; wr_src_o sequence 0,1,0,1 one cycle delayed.
REQ-030 SHALL cover: both valid, wr_stall_i=1 for 3 cycles -> ready=00 and wr_valid_o=0 throughout; first grant after release is requester 0 (p unchanged).
REQ-031 SHALL cover: accept from requester 1 then stall in following cycle -> wr_valid_o still pulses once with requester-1 payload.
REQ-032 SHALL cover: reset asserted mid-stream with both valid -> all outputs 0 immediately; after release first grant to requester 0.
REQ-033 SHALL cover: build with USER_REG_ARB_FIXED_PRIO_EN, both valid 4 cycles -> requester 0 granted every cycle, requester 1 never.
